// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-channel button synchroniser, debouncer, edge pulser and auto-repeat
module button_conditioner #(
    parameter int N_CH            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_PERIOD   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_i,
    input  logic [N_CH-1:0] repeat_en_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o
);

    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [RW-1:0] R_DELAY   = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_PERIOD  = RW'(REPEAT_PERIOD);
    localparam logic [RW-1:0] R_ONE     = RW'(1);
    localparam bit            DB_SINGLE = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        state_t                 state_q, state_d;
        logic [CW-1:0]          cnt_q, cnt_d;
        logic [RW-1:0]          rcnt_q, rcnt_d, rcnt_inc, rep_target;
        logic                   first_done_q, first_done_d;
        logic                   rep_fire;
        logic                   s;
        logic                   level_q, level_d;
        logic                   press_q, press_d;
        logic                   release_q, release_d;

        assign s = sync_q[SYNC_STAGES-1];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_q       <= '0;
                state_q      <= RELEASED;
                cnt_q        <= '0;
                rcnt_q       <= '0;
                first_done_q <= 1'b0;
                level_q      <= 1'b0;
                press_q      <= 1'b0;
                release_q    <= 1'b0;
            end else begin
                sync_q       <= {sync_q[SYNC_STAGES-2:0], btn_i[ch]};
                state_q      <= state_d;
                cnt_q        <= cnt_d;
                rcnt_q       <= rcnt_d;
                first_done_q <= first_done_d;
                level_q      <= level_d;
                press_q      <= press_d;
                release_q    <= release_d;
            end
        end

        // cnt counts agreeing samples seen so far; the change is accepted on the sample that completes the run
        always_comb begin
            state_d      = state_q;
            cnt_d        = cnt_q;
            rcnt_d       = rcnt_q;
            first_done_d = first_done_q;
            level_d      = level_q;
            press_d      = 1'b0;
            release_d    = 1'b0;
            rep_fire     = 1'b0;
            rcnt_inc     = rcnt_q + R_ONE;
            rep_target   = first_done_q ? R_PERIOD : R_DELAY;

            if (state_q == HELD || state_q == RELEASE_CHK) begin
                if (!repeat_en_i[ch]) begin
                    rcnt_d       = '0;
                    first_done_d = 1'b0;
                end else if (rcnt_inc == rep_target) begin
                    rep_fire     = 1'b1;
                    rcnt_d       = '0;
                    first_done_d = 1'b1;
                end else begin
                    rcnt_d = rcnt_inc;
                end
            end

            case (state_q)
                RELEASED: begin
                    if (s) begin
                        if (DB_SINGLE) begin
                            state_d      = HELD;
                            level_d      = 1'b1;
                            press_d      = 1'b1;
                            cnt_d        = '0;
                            rcnt_d       = '0;
                            first_done_d = 1'b0;
                        end else begin
                            state_d = PRESS_CHK;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                PRESS_CHK: begin
                    if (!s) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d      = HELD;
                        level_d      = 1'b1;
                        press_d      = 1'b1;
                        cnt_d        = '0;
                        rcnt_d       = '0;
                        first_done_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                HELD: begin
                    press_d = rep_fire;
                    if (!s) begin
                        if (DB_SINGLE) begin
                            state_d      = RELEASED;
                            level_d      = 1'b0;
                            release_d    = 1'b1;
                            press_d      = 1'b0;
                            cnt_d        = '0;
                            rcnt_d       = '0;
                            first_done_d = 1'b0;
                        end else begin
                            state_d = RELEASE_CHK;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                RELEASE_CHK: begin
                    press_d = rep_fire;
                    if (s) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        // release wins over a repeat falling on the same cycle
                        state_d      = RELEASED;
                        level_d      = 1'b0;
                        release_d    = 1'b1;
                        press_d      = 1'b0;
                        cnt_d        = '0;
                        rcnt_d       = '0;
                        first_done_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end
            endcase
        end

        assign level_o[ch]   = level_q;
        assign press_o[ch]   = press_q;
        assign release_o[ch] = release_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed and random checks of button_conditioner against a window-based model
module tb_button_conditioner;

    localparam int SS = 2;
    localparam int DB = 8;
    localparam int RD = 20;
    localparam int RP = 5;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn   = '0;
    logic [3:0] en    = '0;
    logic [3:0] btn1  = '0;
    logic [3:0] en1   = '0;
    logic [3:0] lvl0, p0, r0, lvl1, p1, r1;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_CH(4), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(rst_n), .btn_i(btn), .repeat_en_i(en),
        .level_o(lvl0), .press_o(p0), .release_o(r0)
    );

    button_conditioner #(
        .N_CH(4), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_db1 (
        .clk(clk), .reset(rst_n), .btn_i(btn1), .repeat_en_i(en1),
        .level_o(lvl1), .press_o(p1), .release_o(r1)
    );

    // model: raw input history, synchronised sample history, accepted level, repeat anchor edge
    bit [31:0]  m_raw    [2][4];
    bit [31:0]  m_sh     [2][4];
    bit         m_lvl    [2][4];
    int         m_anchor [2][4];
    bit         m_first  [2][4];
    logic [3:0] x_lvl [2];
    logic [3:0] x_p   [2];
    logic [3:0] x_r   [2];

    int edge_n   = 0;
    int checks   = 0;
    int failures = 0;

    int cnt_p0 [4];
    int cnt_r0 [4];
    int last_p0[4];
    int last_r0[4];
    int cnt_p1, cnt_r1, last_p1, last_r1;
    int pe2[$];

    function automatic void model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
                m_raw[d][c]    = '0;
                m_sh[d][c]     = '0;
                m_lvl[d][c]    = 1'b0;
                m_anchor[d][c] = 0;
                m_first[d][c]  = 1'b1;
            end
            x_lvl[d] = '0;
            x_p[d]   = '0;
            x_r[d]   = '0;
        end
    endfunction

    // level flips when the last db synchronised samples all disagree with it
    function automatic void model_step(int d, int db, logic [3:0] b, logic [3:0] e);
        bit [31:0] mask;
        bit [31:0] w;
        bit        s;
        int        target;
        mask = (32'd1 << db) - 32'd1;
        for (int c = 0; c < 4; c++) begin
            m_raw[d][c] = {m_raw[d][c][30:0], b[c]};
            s           = m_raw[d][c][SS];
            m_sh[d][c]  = {m_sh[d][c][30:0], s};
            w           = m_sh[d][c] & mask;
            x_p[d][c]   = 1'b0;
            x_r[d][c]   = 1'b0;
            target      = m_first[d][c] ? RD : RP;
            if (!m_lvl[d][c] && w == mask) begin
                m_lvl[d][c]    = 1'b1;
                x_p[d][c]      = 1'b1;
                m_anchor[d][c] = edge_n;
                m_first[d][c]  = 1'b1;
            end else if (m_lvl[d][c] && w == 32'd0) begin
                m_lvl[d][c] = 1'b0;
                x_r[d][c]   = 1'b1;
            end else if (m_lvl[d][c]) begin
                if (!e[c]) begin
                    m_anchor[d][c] = edge_n;
                    m_first[d][c]  = 1'b1;
                end else if (edge_n - m_anchor[d][c] == target) begin
                    x_p[d][c]      = 1'b1;
                    m_anchor[d][c] = edge_n;
                    m_first[d][c]  = 1'b0;
                end
            end
            x_lvl[d][c] = m_lvl[d][c];
        end
    endfunction

    task automatic check_vec(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b edge=%0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d edge=%0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic clear_ev();
        for (int c = 0; c < 4; c++) begin
            cnt_p0[c]  = 0;
            cnt_r0[c]  = 0;
            last_p0[c] = -1;
            last_r0[c] = -1;
        end
        cnt_p1  = 0;
        cnt_r1  = 0;
        last_p1 = -1;
        last_r1 = -1;
        pe2.delete();
    endtask

    function automatic int pe2_at(int i);
        return (i < pe2.size()) ? pe2[i] : -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        edge_n++;
        if (rst_n) begin
            model_step(0, DB, btn, en);
            model_step(1, 1, btn1, en1);
        end else begin
            model_clear();
        end
        #1;
        check_vec("level_db8", lvl0, x_lvl[0]);
        check_vec("press_db8", p0, x_p[0]);
        check_vec("release_db8", r0, x_r[0]);
        check_vec("level_db1", lvl1, x_lvl[1]);
        check_vec("press_db1", p1, x_p[1]);
        check_vec("release_db1", r1, x_r[1]);
        check_vec("press_and_release_db8", p0 & r0, 4'b0000);
        check_vec("press_and_release_db1", p1 & r1, 4'b0000);
        for (int c = 0; c < 4; c++) begin
            if (p0[c]) begin
                cnt_p0[c]++;
                last_p0[c] = edge_n;
                if (c == 2) pe2.push_back(edge_n);
            end
            if (r0[c]) begin
                cnt_r0[c]++;
                last_r0[c] = edge_n;
            end
        end
        if (p1[0]) begin
            cnt_p1++;
            last_p1 = edge_n;
        end
        if (r1[0]) begin
            cnt_r1++;
            last_r1 = edge_n;
        end
        @(negedge clk);
    endtask

    initial begin
        int base;
        model_clear();
        clear_ev();

        // reset state
        @(negedge clk);
        check_vec("reset_level", lvl0, 4'b0000);
        check_vec("reset_press", p0, 4'b0000);
        check_vec("reset_release", r0, 4'b0000);
        repeat (3) tick();
        rst_n = 1'b1;

        // clean press and release on channel 0
        clear_ev();
        base   = edge_n;
        btn[0] = 1'b1;
        repeat (40) tick();
        btn[0] = 1'b0;
        repeat (15) tick();
        check_int("clean_press_count", cnt_p0[0], 1);
        check_int("clean_press_edge", last_p0[0] - base, 10);
        check_int("clean_release_count", cnt_r0[0], 1);
        check_int("clean_release_edge", last_r0[0] - base, 50);

        // bounce on channel 1, then settle high
        clear_ev();
        for (int i = 0; i < 30; i++) begin
            btn[1] = ((i / 3) % 2 == 0);
            tick();
        end
        check_int("bounce_no_press", cnt_p0[1], 0);
        base   = edge_n;
        btn[1] = 1'b1;
        repeat (15) tick();
        check_int("bounce_press_count", cnt_p0[1], 1);
        check_int("bounce_press_edge", last_p0[1] - base, 10);
        btn[1] = 1'b0;
        repeat (15) tick();

        // auto-repeat on channel 2, enabled throughout
        clear_ev();
        base   = edge_n;
        en[2]  = 1'b1;
        btn[2] = 1'b1;
        repeat (60) tick();
        btn[2] = 1'b0;
        repeat (15) tick();
        check_int("repeat_press_edge", pe2_at(0) - base, 10);
        check_int("repeat_first", pe2_at(1) - pe2_at(0), 20);
        check_int("repeat_second", pe2_at(2) - pe2_at(0), 25);
        check_int("repeat_third", pe2_at(3) - pe2_at(0), 30);
        check_int("repeat_count", pe2.size(), 9);
        check_int("repeat_release_edge", last_r0[2] - base, 70);

        // repeat enable dropped at P+22, restored at P+30
        clear_ev();
        base   = edge_n;
        btn[2] = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 32) en[2] = 1'b0;
            if (i == 40) en[2] = 1'b1;
        end
        btn[2] = 1'b0;
        en[2]  = 1'b0;
        repeat (15) tick();
        check_int("drop_first_repeat", pe2_at(1) - base, 30);
        check_int("drop_restart_repeat", pe2_at(2) - base, 60);
        check_int("drop_count", pe2.size(), 3);

        // simultaneous press on all channels
        clear_ev();
        btn = 4'b1111;
        repeat (9) tick();
        check_vec("simul_before", p0, 4'b0000);
        tick();
        check_vec("simul_press", p0, 4'b1111);
        btn = 4'b0000;
        repeat (15) tick();

        // reset while channel 3 is held
        btn[3] = 1'b1;
        repeat (12) tick();
        check_vec("hold_level3", lvl0 & 4'b1000, 4'b1000);
        rst_n = 1'b0;
        #1;
        model_clear();
        check_vec("async_reset_level", lvl0, 4'b0000);
        check_vec("async_reset_press", p0, 4'b0000);
        check_vec("async_reset_release", r0, 4'b0000);
        repeat (3) tick();
        rst_n = 1'b1;
        clear_ev();
        base = edge_n;
        repeat (15) tick();
        check_int("reset_requal_count", cnt_p0[3], 1);
        check_int("reset_requal_edge", last_p0[3] - base, 10);
        btn[3] = 1'b0;
        repeat (15) tick();

        // single-cycle glitch with one-sample debounce
        clear_ev();
        base    = edge_n;
        btn1[0] = 1'b1;
        tick();
        btn1[0] = 1'b0;
        repeat (6) tick();
        check_int("db1_press_count", cnt_p1, 1);
        check_int("db1_release_count", cnt_r1, 1);
        check_int("db1_press_edge", last_p1 - base, 3);
        check_int("db1_release_edge", last_r1 - base, 4);

        // random held runs, glitches and repeat-enable changes
        for (int i = 0; i < 900; i++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 11) == 0) btn[c] = ~btn[c];
                if ($urandom_range(0, 2) == 0) btn1[c] = ~btn1[c];
                if ($urandom_range(0, 39) == 0) en[c] = ~en[c];
                if ($urandom_range(0, 9) == 0) en1[c] = ~en1[c];
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
